// File: rtl/tdc_result_readout.sv
// rtl/tdc_result_readout.sv - TDC result snapshot presented bytewise under an async host strobe
// Optional checksum slot: define TDC_READOUT_CHECKSUM_EN.
module tdc_result_readout #(
  parameter int COUNT_W     = 32,  // multiple of 8, 8..56
  parameter int SYNC_STAGES = 2    // at least 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               meas_done,
  input  logic [COUNT_W-1:0] time_count,
  input  logic               rd_next,
  output logic [7:0]         byte_out,
  output logic [2:0]         byte_idx,
  output logic               data_valid,
  output logic               overflow,
  output logic [7:0]         meas_cnt
);

  localparam int NB = COUNT_W / 8;
`ifdef TDC_READOUT_CHECKSUM_EN
  localparam int LAST = NB;
`else
  localparam int LAST = NB - 1;
`endif
  localparam logic [2:0] LAST_IDX = 3'(LAST);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   adv;

  state_t             state_q;
  logic [COUNT_W-1:0] snap_q;
  logic [7:0]         byte_q;
  logic [2:0]         idx_q;
  logic               valid_q;
  logic               ovf_q;
  logic [7:0]         cnt_q;

  logic [2:0]         idx_d;
  logic [7:0]         slot_d;
  logic               final_adv;

  // Pin strobe through the synchroniser chain plus one edge-detect flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      sync_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], rd_next};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign adv       = sync_q[SYNC_STAGES-1] & ~sync_prev_q;
  assign idx_d     = idx_q + 3'd1;
  assign final_adv = adv && (idx_q == LAST_IDX);

`ifdef TDC_READOUT_CHECKSUM_EN
  logic [7:0] csum;

  // XOR of all snapshot bytes for the trailing checksum slot
  always_comb begin
    csum = '0;
    for (int i = 0; i < NB; i++) csum = csum ^ snap_q[8*i +: 8];
  end
`endif

  // Byte that the next presented slot will show (little-endian)
  always_comb begin
    slot_d = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx_d == 3'(i)) slot_d = snap_q[8*i +: 8];
    end
`ifdef TDC_READOUT_CHECKSUM_EN
    if (idx_d == 3'(NB)) slot_d = csum;
`endif
  end

  // Capture/present FSM with registered outputs; a final advance can retire
  // the old snapshot and accept a new one on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      snap_q  <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (meas_done) begin
            state_q <= HOLD;
            snap_q  <= time_count;
            cnt_q   <= cnt_q + 8'd1;
            valid_q <= 1'b1;
            idx_q   <= '0;
            byte_q  <= time_count[7:0];
          end
        end
        HOLD: begin
          if (final_adv) begin
            if (meas_done) begin
              snap_q  <= time_count;
              cnt_q   <= cnt_q + 8'd1;
              idx_q   <= '0;
              byte_q  <= time_count[7:0];
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              idx_q   <= '0;
              byte_q  <= '0;
            end
          end else begin
            if (meas_done) ovf_q <= 1'b1;
            if (adv) begin
              idx_q  <= idx_d;
              byte_q <= slot_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_out   = byte_q;
  assign byte_idx   = idx_q;
  assign data_valid = valid_q;
  assign overflow   = ovf_q;
  assign meas_cnt   = cnt_q;

endmodule

// File: tb/tb_tdc_result_readout.sv
// tb/tb_tdc_result_readout.sv - self-checking bench for tdc_result_readout
module tb_tdc_result_readout;

  localparam int COUNT_W = 32;
  localparam int S       = 2;
  localparam int NB      = COUNT_W / 8;
`ifdef TDC_READOUT_CHECKSUM_EN
  localparam int SLOTS = NB + 1;
`else
  localparam int SLOTS = NB;
`endif
  localparam int LAST = SLOTS - 1;

  localparam int K_IDLE = 0;
  localparam int K_MEAS = 1;
  localparam int K_EDGE = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               meas_done = 1'b0;
  logic [COUNT_W-1:0] time_count = '0;
  logic               rd_next = 1'b0;
  logic [7:0]         byte_out;
  logic [2:0]         byte_idx;
  logic               data_valid;
  logic               overflow;
  logic [7:0]         meas_cnt;

  int n_total = 0;
  int n_pass  = 0;

  tdc_result_readout #(.COUNT_W(COUNT_W), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .meas_done  (meas_done),
    .time_count (time_count),
    .rd_next    (rd_next),
    .byte_out   (byte_out),
    .byte_idx   (byte_idx),
    .data_valid (data_valid),
    .overflow   (overflow),
    .meas_cnt   (meas_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the snapshot is a queue of slot bytes still to be shown
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic [7:0] m_cnt = 8'd0;
  logic       m_hist[$] = '{0, 0, 0, 0};

  task automatic m_reset();
    m_q.delete();
    m_ovf = 1'b0;
    m_cnt = 8'd0;
    m_hist.delete();
    for (int i = 0; i < S + 2; i++) m_hist.push_back(1'b0);
  endtask

  task automatic m_load(input logic [COUNT_W-1:0] tc);
    logic [7:0] x;
    x = 8'h00;
    m_q.delete();
    for (int i = 0; i < NB; i++) begin
      m_q.push_back(tc[8*i +: 8]);
      x = x ^ tc[8*i +: 8];
    end
`ifdef TDC_READOUT_CHECKSUM_EN
    m_q.push_back(x);
`endif
    m_cnt = m_cnt + 8'd1;
  endtask

  always @(negedge rst_n) m_reset();

  // A pin rise first sampled at edge k yields one advance at edge k+S
  always @(posedge clk) begin
    logic m_adv;
    if (!rst_n) m_reset();
    else begin
      m_hist.push_front(rd_next);
      void'(m_hist.pop_back());
      m_adv = m_hist[S] && !m_hist[S+1];
      if (m_q.size() == 0) begin
        if (meas_done) m_load(time_count);
      end else if (m_adv && m_q.size() == 1) begin
        if (meas_done) m_load(time_count);
        else m_q.delete();
      end else begin
        if (meas_done) m_ovf = 1'b1;
        if (m_adv) void'(m_q.pop_front());
      end
    end
  end

  // Compare every cycle against the model while out of reset
  always @(negedge clk) begin
    logic [7:0] eb;
    logic [2:0] ei;
    if (rst_n) begin
      eb = (m_q.size() > 0) ? m_q[0] : 8'h00;
      ei = (m_q.size() > 0) ? 3'(SLOTS - m_q.size()) : 3'd0;
      chk("model", {13'd0, data_valid, byte_idx, byte_out, overflow, meas_cnt},
          {13'd0, (m_q.size() > 0), ei, eb, m_ovf, m_cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_edge();
    rd_next = 1'b1;
    tick();
    rd_next = 1'b0;
    repeat (S + 1) tick();
  endtask

  task automatic do_meas(input logic [COUNT_W-1:0] tc);
    time_count = tc;
    meas_done  = 1'b1;
    tick();
    meas_done  = 1'b0;
  endtask

  typedef struct {
    int          kind;
    logic [31:0] data;
    logic [7:0]  b;
    logic [2:0]  idx;
    logic        v;
    logic        ov;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{K_IDLE, 32'h0,        8'h00, 3'd0, 1'b0, 1'b0, 8'd0});
    tbl.push_back('{K_MEAS, 32'h12345678, 8'h78, 3'd0, 1'b1, 1'b0, 8'd1});
    tbl.push_back('{K_EDGE, 32'h0,        8'h56, 3'd1, 1'b1, 1'b0, 8'd1});
    tbl.push_back('{K_MEAS, 32'hAABBCCDD, 8'h56, 3'd1, 1'b1, 1'b1, 8'd1});
    tbl.push_back('{K_EDGE, 32'h0,        8'h34, 3'd2, 1'b1, 1'b1, 8'd1});
    tbl.push_back('{K_EDGE, 32'h0,        8'h12, 3'd3, 1'b1, 1'b1, 8'd1});
`ifdef TDC_READOUT_CHECKSUM_EN
    tbl.push_back('{K_EDGE, 32'h0,        8'h08, 3'd4, 1'b1, 1'b1, 8'd1});
`endif
    tbl.push_back('{K_EDGE, 32'h0,        8'h00, 3'd0, 1'b0, 1'b1, 8'd1});

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      case (tbl[i].kind)
        K_IDLE: repeat (20) tick();
        K_MEAS: do_meas(tbl[i].data);
        default: begin
          rd_next = 1'b1;
          repeat (S) tick();
          chk("edge_not_early", byte_idx, tbl[i-1].idx);
          tick();
          rd_next = 1'b0;
        end
      endcase
      chk("tbl_byte",  byte_out,   tbl[i].b);
      chk("tbl_idx",   byte_idx,   tbl[i].idx);
      chk("tbl_valid", data_valid, tbl[i].v);
      chk("tbl_ovf",   overflow,   tbl[i].ov);
      chk("tbl_cnt",   meas_cnt,   tbl[i].cnt);
      tick();
    end

    // Pin held high for 50 cycles gives one advance only
    do_meas(32'h11223344);
    rd_next = 1'b1;
    repeat (50) tick();
    chk("hold_idx",  byte_idx, 32'd1);
    chk("hold_byte", byte_out, 32'h33);
    rd_next = 1'b0;
    tick();
    for (int k = 2; k <= LAST; k++) do_edge();
    chk("at_last_idx", byte_idx, LAST);

    // Final advance coincides with a new measurement
    rd_next = 1'b1;
    tick();
    chk("sim_valid0", data_valid, 32'd1);
    rd_next = 1'b0;
    repeat (S - 1) begin
      tick();
      chk("sim_valid1", data_valid, 32'd1);
    end
    do_meas(32'hDEADBEEF);
    chk("sim_byte",  byte_out,   32'hEF);
    chk("sim_idx",   byte_idx,   32'd0);
    chk("sim_valid", data_valid, 32'd1);
    chk("sim_ovf",   overflow,   32'd1);
    chk("sim_cnt",   meas_cnt,   32'd3);
    do_edge();
    chk("sim_next_byte", byte_out, 32'hBE);
    for (int k = 1; k <= LAST; k++) do_edge();
    chk("sim_done_valid", data_valid, 32'd0);

    // Asynchronous reset in the middle of a readout
    do_meas(32'hCAFEF00D);
    do_edge();
    chk("pre_rst_byte", byte_out, 32'hF0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_byte",  byte_out,   32'd0);
    chk("arst_idx",   byte_idx,   32'd0);
    chk("arst_valid", data_valid, 32'd0);
    chk("arst_ovf",   overflow,   32'd0);
    chk("arst_cnt",   meas_cnt,   32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 256 full captures wrap the counter
    for (int n = 0; n < 256; n++) begin
      do_meas($urandom);
      for (int k = 0; k <= LAST; k++) do_edge();
    end
    chk("wrap_cnt",   meas_cnt,   32'd0);
    chk("wrap_valid", data_valid, 32'd0);
    chk("wrap_ovf",   overflow,   32'd0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      meas_done  = ($urandom_range(0, 9) == 0);
      time_count = $urandom;
      if ($urandom_range(0, 2) == 0) rd_next = ~rd_next;
      tick();
    end
    meas_done = 1'b0;
    rd_next   = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
